// File: rtl/alu_pkg.sv
// alu_pkg -- shared types and constants for the ALU issue controller.
//   NBITS_DEFAULT : default operand width
//   op_e          : ALU opcode (OP_MUL, OP_ADD, OP_LUT, OP_LOGIC)
//   FL_*          : FuncL logic-select encodings
//   pwr_state_e   : power FSM state codes, also visible on pwr_state
//   alu_cmd_t     : command layout {a, b, op, funcl, lut} at default width
package alu_pkg;

  localparam int NBITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    OP_MUL   = 2'd0,
    OP_ADD   = 2'd1,
    OP_LUT   = 2'd2,
    OP_LOGIC = 2'd3
  } op_e;

  // FuncL: 1 AND, 2 OR, 0 and 3 both select XOR.
  localparam logic [1:0] FL_XOR  = 2'd0;
  localparam logic [1:0] FL_AND  = 2'd1;
  localparam logic [1:0] FL_OR   = 2'd2;
  localparam logic [1:0] FL_XOR3 = 2'd3;

  typedef enum logic [1:0] {
    PWR_ACTIVE = 2'd0,
    PWR_DRAIN  = 2'd1,
    PWR_SLEEP  = 2'd2,
    PWR_WAKE   = 2'd3
  } pwr_state_e;

  typedef struct packed {
    logic [NBITS_DEFAULT-1:0] a;
    logic [NBITS_DEFAULT-1:0] b;
    logic [1:0]               op;
    logic [1:0]               funcl;
    logic [NBITS_DEFAULT-1:0] lut;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo -- DEPTH-entry synchronous FIFO for ALU commands.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data when not full (ignored when full, even
//                if a pop happens in the same cycle)
//   push_data  : payload of type T
//   pop        : advance the read pointer when not empty
//   pop_data   : head entry (valid when !empty)
//   full/empty : occupancy flags
// Handshake: an entry moves in only on push & !full, out only on pop & !empty.
module alu_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB tells full (wrapped) from empty (same lap).
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl -- buffers ALU commands and issues them to a power-gated ALU.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : command handshake, transfer when both are 1;
//                        in_ready is simply "FIFO not full" (0 in reset)
//   in_a, in_b, in_op, in_funcl, in_lut : command fields
//   sleep_req          : level request to power the ALU down
//   A, B, OP_CODE, FuncL, Lut_prog : registered operands to the ALU
//   go_sleep           : 1 = ALU running, 0 = ALU powered down
//   res_valid          : ALU output valid, ALU_LAT cycles after operands
//   pwr_state          : FSM state code (ACTIVE 0, DRAIN 1, SLEEP 2, WAKE 3)
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NBITS    = NBITS_DEFAULT,
  parameter int DEPTH    = 4,
  parameter int ALU_LAT  = 1,
  parameter int WAKE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic [1:0]       in_funcl,
  input  logic [NBITS-1:0] in_lut,
  input  logic             sleep_req,
  output logic [NBITS-1:0] A,
  output logic [NBITS-1:0] B,
  output logic [1:0]       OP_CODE,
  output logic [1:0]       FuncL,
  output logic [NBITS-1:0] Lut_prog,
  output logic             go_sleep,
  output logic             res_valid,
  output logic [1:0]       pwr_state
);

  // Same layout as alu_cmd_t, sized by this instance's NBITS.
  typedef struct packed {
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic [1:0]       op;
    logic [1:0]       funcl;
    logic [NBITS-1:0] lut;
  } cmd_t;

  localparam int WCW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYC - 1);

  pwr_state_e     state;
  logic [WCW-1:0] wake_cnt;
  // vpipe[0] marks operands on the ALU this cycle; vpipe[ALU_LAT] is the
  // matching result cycle. Any bit set means a command is still in flight.
  logic [ALU_LAT:0] vpipe;

  cmd_t push_cmd;
  cmd_t head_cmd;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic issue;

  assign in_ready  = rst_n && !fifo_full;
  assign push      = in_valid && in_ready;
  // A raised sleep_req blocks the issue in the very cycle it is seen.
  assign issue     = (state == PWR_ACTIVE) && !sleep_req && !fifo_empty;
  assign res_valid = vpipe[ALU_LAT];
  assign pwr_state = state;

  assign push_cmd = '{a: in_a, b: in_b, op: in_op, funcl: in_funcl, lut: in_lut};

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_cmd),
    .pop       (issue),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PWR_ACTIVE;
      wake_cnt <= '0;
      vpipe    <= '0;
      go_sleep <= 1'b1;
      A        <= '0;
      B        <= '0;
      OP_CODE  <= '0;
      FuncL    <= '0;
      Lut_prog <= '0;
    end else begin
      vpipe <= {vpipe[ALU_LAT-1:0], issue};

      // Operands hold their last value whenever nothing is issued.
      if (issue) begin
        A        <= head_cmd.a;
        B        <= head_cmd.b;
        OP_CODE  <= head_cmd.op;
        FuncL    <= head_cmd.funcl;
        Lut_prog <= head_cmd.lut;
      end

      case (state)
        PWR_ACTIVE: begin
          if (sleep_req) state <= PWR_DRAIN;
        end
        PWR_DRAIN: begin
          if (!sleep_req) begin
            state <= PWR_ACTIVE;
          end else if (vpipe == '0) begin
            // Nothing in flight: power down and isolate the ALU inputs.
            state    <= PWR_SLEEP;
            go_sleep <= 1'b0;
            A        <= '0;
            B        <= '0;
            OP_CODE  <= '0;
            FuncL    <= '0;
            Lut_prog <= '0;
          end
        end
        PWR_SLEEP: begin
          A        <= '0;
          B        <= '0;
          OP_CODE  <= '0;
          FuncL    <= '0;
          Lut_prog <= '0;
          if (!sleep_req) begin
            state    <= PWR_WAKE;
            go_sleep <= 1'b1;
            wake_cnt <= '0;
          end
        end
        PWR_WAKE: begin
          // Supply settling; sleep_req is not looked at until ACTIVE.
          if (wake_cnt == WAKE_LAST) begin
            state <= PWR_ACTIVE;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end
        default: state <= PWR_ACTIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl -- directed bench for alu_issue_ctrl (default parameters).
module tb_alu_issue_ctrl;

  localparam int NBITS = 8;
  localparam int CW    = 3 * NBITS + 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] in_a;
  logic [NBITS-1:0] in_b;
  logic [1:0]       in_op;
  logic [1:0]       in_funcl;
  logic [NBITS-1:0] in_lut;
  logic             sleep_req;
  logic [NBITS-1:0] A;
  logic [NBITS-1:0] B;
  logic [1:0]       OP_CODE;
  logic [1:0]       FuncL;
  logic [NBITS-1:0] Lut_prog;
  logic             go_sleep;
  logic             res_valid;
  logic [1:0]       pwr_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] prev_ops;
  logic [CW-1:0] exp_ops;
  logic [15:0]   alu_o;

  alu_issue_ctrl #(
    .NBITS    (8),
    .DEPTH    (4),
    .ALU_LAT  (1),
    .WAKE_CYC (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_funcl  (in_funcl),
    .in_lut    (in_lut),
    .sleep_req (sleep_req),
    .A         (A),
    .B         (B),
    .OP_CODE   (OP_CODE),
    .FuncL     (FuncL),
    .Lut_prog  (Lut_prog),
    .go_sleep  (go_sleep),
    .res_valid (res_valid),
    .pwr_state (pwr_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                           input logic [1:0] fl, input logic [7:0] lut);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_funcl = fl;
    in_lut   = lut;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  // Accepted commands queue up in order; each res_valid must match the
  // operands that sat on the ALU outputs one cycle earlier (ALU_LAT = 1).
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("res_unexpected", 64'(res_valid), 64'(0));
        end else begin
          exp_ops = exp_q.pop_front();
          check_eq("res_order", 64'(prev_ops), 64'(exp_ops));
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_a, in_b, in_op, in_funcl, in_lut});
    end
    prev_ops <= {A, B, OP_CODE, FuncL, Lut_prog};
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_funcl  = '0;
    in_lut    = '0;
    sleep_req = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'(0));
    check_eq("rst_go_sleep", 64'(go_sleep), 64'(1));
    check_eq("rst_res_valid", 64'(res_valid), 64'(0));
    check_eq("rst_A", 64'(A), 64'(0));
    check_eq("rst_B", 64'(B), 64'(0));
    check_eq("rst_op", 64'(OP_CODE), 64'(0));
    check_eq("rst_lut", 64'(Lut_prog), 64'(0));
    check_eq("rst_state", 64'(pwr_state), 64'(0));
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", 64'(in_ready), 64'(1));

    // 3 + 5 ADD: accept, issue next cycle, result one cycle after operands
    drive_cmd(8'd3, 8'd5, 2'd1, 2'd0, 8'd0);
    step();
    idle_in();
    check_eq("add_A_not_yet", 64'(A), 64'(0));
    step();
    check_eq("add_A", 64'(A), 64'(3));
    check_eq("add_B", 64'(B), 64'(5));
    check_eq("add_op", 64'(OP_CODE), 64'(1));
    check_eq("add_res_early", 64'(res_valid), 64'(0));
    alu_o = 16'(A) + 16'(B);
    check_eq("add_O", 64'(alu_o), 64'(8));
    step();
    check_eq("add_res_valid", 64'(res_valid), 64'(1));
    step();
    check_eq("add_res_single", 64'(res_valid), 64'(0));

    // Fill the FIFO while sleeping; 5th command waits for wake + one issue
    sleep_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(8'(16 + i), 8'(32 + i), 2'(i), 2'd2, 8'(64 + i));
      check_eq("fill_ready", 64'(in_ready), 64'(1));
      step();
    end
    drive_cmd(8'h55, 8'h66, 2'd3, 2'd1, 8'h77);
    check_eq("full_ready", 64'(in_ready), 64'(0));
    check_eq("full_state_sleep", 64'(pwr_state), 64'(2));
    check_eq("full_go_sleep", 64'(go_sleep), 64'(0));
    check_eq("iso_A", 64'(A), 64'(0));
    sleep_req = 1'b0;
    step();
    check_eq("wake_state", 64'(pwr_state), 64'(3));
    check_eq("wake_go_sleep", 64'(go_sleep), 64'(1));
    check_eq("wake_ready", 64'(in_ready), 64'(0));
    repeat (3) step();
    check_eq("wake_last_state", 64'(pwr_state), 64'(3));
    step();
    check_eq("act_state", 64'(pwr_state), 64'(0));
    check_eq("act_pop_no_push", 64'(in_ready), 64'(0));
    step();
    check_eq("after_issue_ready", 64'(in_ready), 64'(1));
    check_eq("first_issue_A", 64'(A), 64'h10);
    step();
    idle_in();
    repeat (6) step();
    check_eq("fill_sb_empty", 64'(exp_q.size()), 64'(0));

    // Two issued commands, then sleep: drain both results, then isolate
    drive_cmd(8'd10, 8'd20, 2'd3, 2'd1, 8'hA5);
    step();
    drive_cmd(8'd7, 8'd9, 2'd2, 2'd0, 8'h3C);
    step();
    idle_in();
    step();
    sleep_req = 1'b1;
    check_eq("drain_res1", 64'(res_valid), 64'(1));
    step();
    check_eq("drain_state", 64'(pwr_state), 64'(1));
    check_eq("drain_res2", 64'(res_valid), 64'(1));
    check_eq("drain_go_sleep", 64'(go_sleep), 64'(1));
    step();
    check_eq("drain_hold", 64'(pwr_state), 64'(1));
    step();
    check_eq("sleep_state", 64'(pwr_state), 64'(2));
    check_eq("sleep_go_sleep", 64'(go_sleep), 64'(0));
    check_eq("sleep_A", 64'(A), 64'(0));
    check_eq("sleep_B", 64'(B), 64'(0));
    check_eq("sleep_op", 64'(OP_CODE), 64'(0));
    check_eq("sleep_funcl", 64'(FuncL), 64'(0));
    check_eq("sleep_lut", 64'(Lut_prog), 64'(0));

    // Push 255*255 while asleep; sleep_req blip in WAKE is ignored
    drive_cmd(8'd255, 8'd255, 2'd0, 2'd0, 8'd0);
    step();
    idle_in();
    check_eq("sleep_push_state", 64'(pwr_state), 64'(2));
    check_eq("sleep_push_iso", 64'(A), 64'(0));
    sleep_req = 1'b0;
    step();
    check_eq("mul_wake1", 64'(pwr_state), 64'(3));
    sleep_req = 1'b1;
    step();
    sleep_req = 1'b0;
    check_eq("mul_wake2_ignore", 64'(pwr_state), 64'(3));
    repeat (2) step();
    check_eq("mul_wake4", 64'(pwr_state), 64'(3));
    step();
    check_eq("mul_active", 64'(pwr_state), 64'(0));
    check_eq("mul_A_not_yet", 64'(A), 64'(0));
    step();
    check_eq("mul_A", 64'(A), 64'(255));
    check_eq("mul_B", 64'(B), 64'(255));
    check_eq("mul_op", 64'(OP_CODE), 64'(0));
    alu_o = 16'(A) * 16'(B);
    check_eq("mul_O", 64'(alu_o), 64'(65025));
    step();
    check_eq("mul_res_valid", 64'(res_valid), 64'(1));

    // One-cycle sleep_req pulse with a command in flight: back to ACTIVE
    drive_cmd(8'h2A, 8'h15, 2'd1, 2'd3, 8'h0F);
    step();
    idle_in();
    step();
    sleep_req = 1'b1;
    step();
    sleep_req = 1'b0;
    check_eq("pulse_drain", 64'(pwr_state), 64'(1));
    check_eq("pulse_go_sleep", 64'(go_sleep), 64'(1));
    check_eq("pulse_res", 64'(res_valid), 64'(1));
    step();
    check_eq("pulse_back_active", 64'(pwr_state), 64'(0));
    check_eq("pulse_go_sleep2", 64'(go_sleep), 64'(1));
    repeat (2) step();
    check_eq("empty_hold_A", 64'(A), 64'h2A);
    check_eq("empty_hold_B", 64'(B), 64'h15);
    check_eq("empty_no_res", 64'(res_valid), 64'(0));
    check_eq("pulse_sb_empty", 64'(exp_q.size()), 64'(0));

    // Reset while draining with three commands queued
    drive_cmd(8'd1, 8'd2, 2'd1, 2'd0, 8'd0);
    step();
    drive_cmd(8'd3, 8'd4, 2'd1, 2'd0, 8'd0);
    step();
    drive_cmd(8'd5, 8'd6, 2'd1, 2'd0, 8'd0);
    sleep_req = 1'b1;
    step();
    drive_cmd(8'd7, 8'd8, 2'd1, 2'd0, 8'd0);
    check_eq("rd_drain", 64'(pwr_state), 64'(1));
    step();
    idle_in();
    sleep_req = 1'b0;
    check_eq("rd_drain2", 64'(pwr_state), 64'(1));
    rst_n = 1'b0;
    #1;
    check_eq("rd_state", 64'(pwr_state), 64'(0));
    check_eq("rd_go_sleep", 64'(go_sleep), 64'(1));
    check_eq("rd_res", 64'(res_valid), 64'(0));
    check_eq("rd_A", 64'(A), 64'(0));
    check_eq("rd_in_ready", 64'(in_ready), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("rd_no_res", 64'(res_valid), 64'(0));
    end
    check_eq("rd_ready_after", 64'(in_ready), 64'(1));
    check_eq("rd_A_after", 64'(A), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
